// File: rtl/scirc_updn_mod_counter.sv
// Modulo-MODULUS up/down counter driven by a 2-bit command, with a registered
// one-cycle boundary flag and last-direction output; wraps or saturates per WRAP.
module scirc_updn_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int WRAP    = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       x_i,
    output logic [WIDTH-1:0] count_o,
    output logic             y_out,
    output logic             dir_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_UP    = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("scirc_updn_mod_counter: illegal WIDTH/MODULUS combination");
    end

    // A full-range modulus makes every encoding legal, so no recovery compare exists.
    logic out_of_range;
    if (MODULUS == (1 << WIDTH)) begin : g_full
        assign out_of_range = 1'b0;
    end else begin : g_part
        assign out_of_range = (count_o > MAX_C);
    end

    logic [WIDTH-1:0] count_nxt;
    logic             y_nxt;
    logic             dir_nxt;

    always_comb begin
        count_nxt = count_o;
        y_nxt     = 1'b0;
        dir_nxt   = dir_o;
        case (x_i)
            CMD_UP: begin
                dir_nxt = 1'b1;
                if (out_of_range) begin
                    count_nxt = '0;
                    y_nxt     = 1'b1;
                end else if (count_o == MAX_C) begin
                    y_nxt = 1'b1;
                    if (WRAP != 0) count_nxt = '0;
                end else begin
                    count_nxt = count_o + WIDTH'(1);
                end
            end
            CMD_DOWN: begin
                dir_nxt = 1'b0;
                if (out_of_range) begin
                    count_nxt = '0;
                    y_nxt     = 1'b1;
                end else if (count_o == '0) begin
                    y_nxt = 1'b1;
                    if (WRAP != 0) count_nxt = MAX_C;
                end else begin
                    count_nxt = count_o - WIDTH'(1);
                end
            end
            CMD_CLEAR: begin
                count_nxt = '0;
                dir_nxt   = 1'b1;
            end
            CMD_HOLD: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_o <= '0;
            y_out   <= 1'b0;
            dir_o   <= 1'b1;
        end else begin
            count_o <= count_nxt;
            y_out   <= y_nxt;
            dir_o   <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_scirc_updn_mod_counter.sv
// Bench for scirc_updn_mod_counter: three configurations share clock and reset,
// checked each cycle against an arithmetic model plus literal plan expectations.
module tb_scirc_updn_mod_counter;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] xa = 2'b00, xb = 2'b00, xc = 2'b00;
    logic [3:0] ca, cb;
    logic [2:0] cc;
    logic       ya, yb, yc, da, db, dc;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    scirc_updn_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1)) u_a (
        .clk_i(clk_sys), .rst_i(rst_n), .x_i(xa), .count_o(ca), .y_out(ya), .dir_o(da));
    scirc_updn_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAP(0)) u_b (
        .clk_i(clk_sys), .rst_i(rst_n), .x_i(xb), .count_o(cb), .y_out(yb), .dir_o(db));
    scirc_updn_mod_counter #(.WIDTH(3), .MODULUS(8), .WRAP(1)) u_c (
        .clk_i(clk_sys), .rst_i(rst_n), .x_i(xc), .count_o(cc), .y_out(yc), .dir_o(dc));

    int mm[3] = '{10, 10, 8};
    bit mw[3] = '{1'b1, 1'b0, 1'b1};
    int mc[3];
    bit my[3];
    bit md[3];

    function automatic int nxt_c(int m, bit w, logic [1:0] x, int c);
        case (x)
            2'b01:   return w ? (c + 1) % m : ((c + 1 < m) ? c + 1 : m - 1);
            2'b10:   return w ? (c + m - 1) % m : ((c > 0) ? c - 1 : 0);
            2'b11:   return 0;
            default: return c;
        endcase
    endfunction

    function automatic bit nxt_y(int m, logic [1:0] x, int c);
        return (x == 2'b01 && c == m - 1) || (x == 2'b10 && c == 0);
    endfunction

    function automatic bit nxt_d(logic [1:0] x, bit d);
        return (x == 2'b10) ? 1'b0 : (x == 2'b00) ? d : 1'b1;
    endfunction

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mc[k] <= 0;
                my[k] <= 1'b0;
                md[k] <= 1'b1;
            end
        end else begin
            logic [1:0] xs[3];
            xs[0] = xa; xs[1] = xb; xs[2] = xc;
            for (int k = 0; k < 3; k++) begin
                mc[k] <= nxt_c(mm[k], mw[k], xs[k], mc[k]);
                my[k] <= nxt_y(mm[k], xs[k], mc[k]);
                md[k] <= nxt_d(xs[k], md[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_n) begin
            chk("model_a_count", 32'(ca), 32'(mc[0]));
            chk("model_a_y",     32'(ya), 32'(my[0]));
            chk("model_a_dir",   32'(da), 32'(md[0]));
            chk("model_b_count", 32'(cb), 32'(mc[1]));
            chk("model_b_y",     32'(yb), 32'(my[1]));
            chk("model_b_dir",   32'(db), 32'(md[1]));
            chk("model_c_count", 32'(cc), 32'(mc[2]));
            chk("model_c_y",     32'(yc), 32'(my[2]));
            chk("model_c_dir",   32'(dc), 32'(md[2]));
        end
    end

    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        xa = a; xb = b; xc = c;
        @(posedge clk_sys);
        #2;
    endtask

    initial begin
        int exp_a1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int exp_a2[3]  = '{9, 8, 7};
        int exp_c6[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        int exp_c6b[3] = '{0, 1, 0};
        logic [1:0] alt[3];

        #23;
        chk("reset_count", 32'(ca), 0);
        chk("reset_y",     32'(ya), 0);
        chk("reset_dir",   32'(da), 1);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // plan 1: wrap upward at defaults
        for (int i = 0; i < 12; i++) begin
            step(2'b01, 2'b00, 2'b00);
            chk("p1_count", 32'(ca), 32'(exp_a1[i]));
            chk("p1_y",     32'(ya), (exp_a1[i] == 0 && i == 9) ? 1 : 0);
            chk("p1_dir",   32'(da), 1);
            chk("p1_model", 32'(mc[0]), 32'(exp_a1[i]));
        end

        // plan 2: wrap downward from zero
        step(2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b00, 2'b00);
            chk("p2_count", 32'(ca), 32'(exp_a2[i]));
            chk("p2_y",     32'(ya), (i == 0) ? 1 : 0);
            chk("p2_dir",   32'(da), 0);
        end

        // plan 4: clear from 5, then repeated clear
        step(2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 2'b00);
        chk("p4_pre", 32'(ca), 5);
        for (int i = 0; i < 2; i++) begin
            step(2'b11, 2'b00, 2'b00);
            chk("p4_count", 32'(ca), 0);
            chk("p4_y",     32'(ya), 0);
            chk("p4_dir",   32'(da), 1);
        end
        step(2'b10, 2'b00, 2'b00);
        step(2'b11, 2'b00, 2'b00);
        chk("p4_clear_after_down_y",   32'(ya), 0);
        chk("p4_clear_after_down_dir", 32'(da), 1);

        // plan 5: asynchronous reset mid-cycle
        for (int i = 0; i < 6; i++) step(2'b01, 2'b00, 2'b00);
        chk("p5_pre", 32'(ca), 6);
        rst_n = 1'b0;
        #2;
        chk("p5_async_count", 32'(ca), 0);
        chk("p5_async_y",     32'(ya), 0);
        chk("p5_async_dir",   32'(da), 1);
        rst_n = 1'b1;
        step(2'b01, 2'b00, 2'b00);
        chk("p5_first_edge", 32'(ca), 1);

        // plan 3: saturation at top with repeated boundary flags
        for (int i = 0; i < 9; i++) step(2'b00, 2'b01, 2'b00);
        chk("p3_pre", 32'(cb), 9);
        chk("p3_pre_y", 32'(yb), 0);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'b01, 2'b00);
            chk("p3_sat_count", 32'(cb), 9);
            chk("p3_sat_y",     32'(yb), 1);
        end
        step(2'b00, 2'b00, 2'b00);
        chk("p3_hold_y",     32'(yb), 0);
        chk("p3_hold_count", 32'(cb), 9);

        // plan 6: full-range modulus, then direction reversal
        for (int i = 0; i < 9; i++) begin
            step(2'b00, 2'b00, 2'b01);
            chk("p6_count", 32'(cc), 32'(exp_c6[i]));
            chk("p6_y",     32'(yc), (i == 7) ? 1 : 0);
        end
        alt[0] = 2'b10; alt[1] = 2'b01; alt[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'b00, alt[i]);
            chk("p6_alt_count", 32'(cc), 32'(exp_c6b[i]));
            chk("p6_alt_y",     32'(yc), 0);
            chk("p6_alt_dir",   32'(dc), (alt[i] == 2'b01) ? 1 : 0);
        end

        // randomized traffic, biased toward counting so bounds are hit often
        for (int i = 0; i < 600; i++) begin
            logic [1:0] r[3];
            for (int k = 0; k < 3; k++) begin
                int p;
                p = int'($urandom_range(0, 15));
                r[k] = (p < 7) ? 2'b01 : (p < 12) ? 2'b10 : (p < 15) ? 2'b00 : 2'b11;
            end
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk_sys);
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step(r[0], r[1], r[2]);
        end

        @(negedge clk_sys);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
